// File: rtl/segment_transition_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// segment_transition_ctrl_pkg
//
// Shared types and constants for the segment transition controller and its
// trigger evaluator.
//
//   REP_INFINITE         all-ones repetition value at the default width;
//                        a segment with this repetition count loops forever
//   segment_fsm_state_t  controller FSM: ST_RUN (no request armed) and
//                        ST_WAIT (request armed, waiting for its trigger)
//   transition_mode_t    encoding of the TRANSITION_MODE register
//   mode_known()         1 when a mode code is accepted by this build
//
// Configuration macro: SEGMENT_TRANSITION_EXT_EN makes MODE_EXT a known mode.
// ---------------------------------------------------------------------------
package segment_transition_ctrl_pkg;

  localparam int REP_W_DEFAULT = 16;
  localparam logic [REP_W_DEFAULT-1:0] REP_INFINITE = '1;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } segment_fsm_state_t;

  typedef enum logic [7:0] {
    MODE_SYNC_IDX = 8'h00,
    MODE_SYS_TIME = 8'h01,
    MODE_GPIO     = 8'h02,
    MODE_EXT      = 8'hF0
  } transition_mode_t;

  function automatic logic mode_known(input logic [7:0] mode);
    logic known;
    known = 1'b0;
    case (mode)
      MODE_SYNC_IDX: known = 1'b1;
      MODE_SYS_TIME: known = 1'b1;
      MODE_GPIO:     known = 1'b1;
`ifdef SEGMENT_TRANSITION_EXT_EN
      MODE_EXT:      known = 1'b1;
`endif
      default:       known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/segment_transition_ctrl_trigger.sv
// ---------------------------------------------------------------------------
// segment_transition_ctrl_trigger
//
// Evaluates the transition condition for the currently armed request and
// raises FIRE for each cycle in which it holds. It keeps no segment state;
// its only storage is the previous-cycle GPIO sample used for edge detection.
//
// Ports
//   CLK, RST    clock, synchronous active-high reset
//   MODE        armed transition mode (transition_mode_t code)
//   VALUE       armed transition value: sys-time target or GPIO index [1:0]
//   SYS_TIME    free-running system time
//   LOOP_END    sampler wrapped its index this cycle
//   STOP        controller STOP flag (segment already finished)
//   GPIO_IN     synchronised GPIO inputs
//   FIRE        condition met this cycle (combinational)
//
// Configuration macro: SEGMENT_TRANSITION_EXT_EN adds MODE_EXT, which fires
// like MODE_SYNC_IDX.
// ---------------------------------------------------------------------------
module segment_transition_ctrl_trigger
  import segment_transition_ctrl_pkg::*;
#(
  parameter int SYS_TIME_W = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            MODE,
  input  logic [SYS_TIME_W-1:0] VALUE,
  input  logic [SYS_TIME_W-1:0] SYS_TIME,
  input  logic                  LOOP_END,
  input  logic                  STOP,
  input  logic [3:0]            GPIO_IN,
  output logic                  FIRE
);

  logic [3:0] gpio_prev_q;
  logic [1:0] gpio_sel;

  assign gpio_sel = VALUE[1:0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      gpio_prev_q <= 4'b0000;
    end else begin
      gpio_prev_q <= GPIO_IN;
    end
  end

  always_comb begin
    FIRE = 1'b0;
    case (MODE)
      // A stopped segment produces no further LOOP_END, so STOP stands in
      // for the loop boundary that will never come.
      MODE_SYNC_IDX: FIRE = LOOP_END || STOP;
      MODE_SYS_TIME: FIRE = (SYS_TIME >= VALUE);
      MODE_GPIO:     FIRE = GPIO_IN[gpio_sel] && !gpio_prev_q[gpio_sel];
`ifdef SEGMENT_TRANSITION_EXT_EN
      MODE_EXT:      FIRE = LOOP_END || STOP;
`endif
      default:       FIRE = 1'b0;
    endcase
  end

endmodule

// File: rtl/segment_transition_ctrl.sv
// ---------------------------------------------------------------------------
// segment_transition_ctrl
//
// N-segment playback controller for one modulation/STM engine. Tracks the
// active segment, counts loop repetitions, raises STOP when a finite
// repetition count is used up, and swaps segments when an armed request's
// trigger fires (SYNC_IDX, SYS_TIME, GPIO, optionally EXT).
//
// Ports
//   CLK, RST          clock, synchronous active-high reset
//   UPDATE            one-cycle pulse: latch REQ_SEGMENT/TRANSITION_MODE/
//                     TRANSITION_VALUE as the pending request
//   REQ_SEGMENT       requested segment
//   TRANSITION_MODE   transition_mode_t code
//   TRANSITION_VALUE  sys-time target (SYS_TIME) or GPIO index [1:0] (GPIO)
//   REP               per-segment repetition counts, segment s at
//                     [s*REP_W +: REP_W]; loop plays REP+1 times, all-ones
//                     means infinite
//   LOOP_END          sampler index wrapped to 0 this cycle
//   SYS_TIME          free-running system time
//   GPIO_IN           synchronised GPIO inputs
//   SEGMENT           active segment
//   SWAP              one-cycle pulse in the cycle SEGMENT changes
//   STOP              finite repetitions exhausted (sticky until a swap)
//   PENDING           request armed, not yet taken
//   REQ_ERR           one-cycle pulse: UPDATE rejected
//   DBG_STATE         FSM state (segment_fsm_state_t)
//   DBG_REP_CNT       repetition counter of the active segment
//
// Handshake: UPDATE, LOOP_END are single-cycle strobes with no back-pressure;
// SWAP and REQ_ERR are single-cycle strobes, all outputs are registered.
//
// Configuration macro: SEGMENT_TRANSITION_EXT_EN enables EXT mode, which
// swaps like SYNC_IDX and then auto-advances to the next segment each time
// the active one finishes, never asserting STOP, until the next accepted
// UPDATE. Without the macro EXT is rejected like any unknown mode.
// ---------------------------------------------------------------------------
module segment_transition_ctrl
  import segment_transition_ctrl_pkg::*;
#(
  parameter int NUM_SEGMENT = 2,
  parameter int REP_W       = 16,
  parameter int SYS_TIME_W  = 64,
  localparam int SEG_W      = $clog2(NUM_SEGMENT)
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         UPDATE,
  input  logic [SEG_W-1:0]             REQ_SEGMENT,
  input  logic [7:0]                   TRANSITION_MODE,
  input  logic [SYS_TIME_W-1:0]        TRANSITION_VALUE,
  input  logic [NUM_SEGMENT*REP_W-1:0] REP,
  input  logic                         LOOP_END,
  input  logic [SYS_TIME_W-1:0]        SYS_TIME,
  input  logic [3:0]                   GPIO_IN,
  output logic [SEG_W-1:0]             SEGMENT,
  output logic                         SWAP,
  output logic                         STOP,
  output logic                         PENDING,
  output logic                         REQ_ERR,
  output logic                         DBG_STATE,
  output logic [REP_W-1:0]             DBG_REP_CNT
);

  segment_fsm_state_t     state_q;
  logic [SEG_W-1:0]       segment_q;
  logic [SEG_W-1:0]       req_seg_q;
  logic [7:0]             mode_q;
  logic [SYS_TIME_W-1:0]  value_q;
  logic [REP_W-1:0]       rep_cnt_q;
  logic                   swap_q;
  logic                   stop_q;
  logic                   pending_q;
  logic                   req_err_q;
  logic                   ext_q;

  logic [REP_W-1:0]       rep_cur;
  logic                   rep_finite;
  logic                   rep_done;
  logic                   req_valid;
  logic                   accept;
  logic                   fire;
  logic                   take;
  logic                   adv;
  logic [SEG_W-1:0]       seg_next;

  assign rep_cur    = REP[int'(segment_q)*REP_W +: REP_W];
  assign rep_finite = (rep_cur != {REP_W{1'b1}});
  // The loop boundary that completes the last repetition of this segment.
  assign rep_done   = LOOP_END && rep_finite && (rep_cnt_q == rep_cur);

  assign req_valid  = (int'(REQ_SEGMENT) < NUM_SEGMENT) && mode_known(TRANSITION_MODE);
  assign accept     = UPDATE && req_valid;

  // An accepted UPDATE replaces the armed request, so it suppresses a
  // trigger firing for the request it replaces.
  assign take       = (state_q == ST_WAIT) && fire && !accept;

  // Auto-advance only ever happens in EXT playback; ext_q is constant 0
  // otherwise.
  assign adv        = ext_q && rep_done;
  assign seg_next   = (int'(segment_q) == NUM_SEGMENT - 1) ? '0 : segment_q + 1'b1;

  segment_transition_ctrl_trigger #(
    .SYS_TIME_W (SYS_TIME_W)
  ) u_transition_trigger (
    .CLK      (CLK),
    .RST      (RST),
    .MODE     (mode_q),
    .VALUE    (value_q),
    .SYS_TIME (SYS_TIME),
    .LOOP_END (LOOP_END),
    .STOP     (stop_q),
    .GPIO_IN  (GPIO_IN),
    .FIRE     (fire)
  );

`ifndef SEGMENT_TRANSITION_EXT_EN
  assign ext_q = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_RUN;
      segment_q <= '0;
      req_seg_q <= '0;
      mode_q    <= 8'h00;
      value_q   <= '0;
      rep_cnt_q <= '0;
      swap_q    <= 1'b0;
      stop_q    <= 1'b0;
      pending_q <= 1'b0;
      req_err_q <= 1'b0;
`ifdef SEGMENT_TRANSITION_EXT_EN
      ext_q     <= 1'b0;
`endif
    end else begin
      swap_q    <= 1'b0;
      req_err_q <= 1'b0;

      // Segment / repetition bookkeeping. A swap takes priority over a
      // coincident LOOP_END, which is then not counted on the new segment.
      if (take) begin
        segment_q <= req_seg_q;
        rep_cnt_q <= '0;
        stop_q    <= 1'b0;
        swap_q    <= 1'b1;
        state_q   <= ST_RUN;
        pending_q <= 1'b0;
`ifdef SEGMENT_TRANSITION_EXT_EN
        ext_q     <= (mode_q == MODE_EXT);
`endif
      end else if (adv) begin
        segment_q <= seg_next;
        rep_cnt_q <= '0;
        swap_q    <= 1'b1;
      end else if (LOOP_END && rep_finite) begin
        // rep_cnt stops at REP, which is below all-ones, so it cannot wrap.
        if (rep_cnt_q == rep_cur) begin
          stop_q <= 1'b1;
        end else begin
          rep_cnt_q <= rep_cnt_q + 1'b1;
        end
      end

      // Request handling; take is never set in the same cycle as accept.
      if (UPDATE) begin
        if (req_valid) begin
          req_seg_q <= REQ_SEGMENT;
          mode_q    <= TRANSITION_MODE;
          value_q   <= TRANSITION_VALUE;
          state_q   <= ST_WAIT;
          pending_q <= 1'b1;
`ifdef SEGMENT_TRANSITION_EXT_EN
          ext_q     <= 1'b0;
`endif
        end else begin
          req_err_q <= 1'b1;
        end
      end
    end
  end

  assign SEGMENT     = segment_q;
  assign SWAP        = swap_q;
  assign STOP        = stop_q;
  assign PENDING     = pending_q;
  assign REQ_ERR     = req_err_q;
  assign DBG_STATE   = state_q;
  assign DBG_REP_CNT = rep_cnt_q;

endmodule

// File: tb/tb_segment_transition_ctrl.sv
module tb_segment_transition_ctrl;
  import segment_transition_ctrl_pkg::*;

  localparam int NUM_SEGMENT = 3;
  localparam int REP_W       = 16;
  localparam int SYS_TIME_W  = 64;
  localparam int SEG_W       = $clog2(NUM_SEGMENT);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                         update = 1'b0;
  logic [SEG_W-1:0]             req_segment = '0;
  logic [7:0]                   transition_mode = 8'h00;
  logic [SYS_TIME_W-1:0]        transition_value = '0;
  logic [NUM_SEGMENT*REP_W-1:0] rep = '0;
  logic                         loop_end = 1'b0;
  logic [SYS_TIME_W-1:0]        sys_time = '0;
  logic [3:0]                   gpio_in = 4'b0000;
  logic [SEG_W-1:0]             segment;
  logic                         swap, stop, pending, req_err, dbg_state;
  logic [REP_W-1:0]             dbg_rep_cnt;

  segment_transition_ctrl #(
    .NUM_SEGMENT (NUM_SEGMENT),
    .REP_W       (REP_W),
    .SYS_TIME_W  (SYS_TIME_W)
  ) dut (
    .CLK              (clk),
    .RST              (rst),
    .UPDATE           (update),
    .REQ_SEGMENT      (req_segment),
    .TRANSITION_MODE  (transition_mode),
    .TRANSITION_VALUE (transition_value),
    .REP              (rep),
    .LOOP_END         (loop_end),
    .SYS_TIME         (sys_time),
    .GPIO_IN          (gpio_in),
    .SEGMENT          (segment),
    .SWAP             (swap),
    .STOP             (stop),
    .PENDING          (pending),
    .REQ_ERR          (req_err),
    .DBG_STATE        (dbg_state),
    .DBG_REP_CNT      (dbg_rep_cnt)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Expected segment of every SWAP pulse, pushed before the stimulus that
  // should cause it.
  logic [SEG_W-1:0] exp_q[$];

  always @(negedge clk) begin
    if (!rst && swap) begin
      if (exp_q.size() == 0) chk("swap_unexpected", 64'(segment), 64'hFFFF);
      else chk("swap_segment", 64'(segment), 64'(exp_q.pop_front()));
    end
  end

  // ---------------- drivers ----------------
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_loop_end();
    loop_end = 1'b1;
    tick();
    loop_end = 1'b0;
  endtask

  task automatic do_update(input logic [SEG_W-1:0] seg, input logic [7:0] mode,
                           input logic [SYS_TIME_W-1:0] val);
    req_segment      = seg;
    transition_mode  = mode;
    transition_value = val;
    update           = 1'b1;
    tick();
    update           = 1'b0;
  endtask

  task automatic rand_gap();
    tick($urandom_range(0, 3));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    // seg0 plays 3 times, seg1 plays 6 times, seg2 loops forever
    rep = {REP_INFINITE, 16'd5, 16'd2};
    tick(3);
    chk("rst_segment", 64'(segment), 0);
    chk("rst_swap", 64'(swap), 0);
    chk("rst_stop", 64'(stop), 0);
    chk("rst_pending", 64'(pending), 0);
    chk("rst_req_err", 64'(req_err), 0);
    chk("rst_rep_cnt", 64'(dbg_rep_cnt), 0);
    chk("rst_state", 64'(dbg_state), 0);
    rst = 1'b0;
    tick(2);

    // SYNC_IDX swap: waits for the LOOP_END, swaps one cycle later
    do_update(1, MODE_SYNC_IDX, '0);
    chk("sync_pending", 64'(pending), 1);
    chk("sync_state", 64'(dbg_state), 1);
    tick(4);
    chk("sync_wait_seg", 64'(segment), 0);
    chk("sync_wait_swap", 64'(swap), 0);
    exp_q.push_back(1);
    pulse_loop_end();
    chk("sync_swap", 64'(swap), 1);
    chk("sync_seg", 64'(segment), 1);
    chk("sync_rep_cnt", 64'(dbg_rep_cnt), 0);
    chk("sync_pending_clr", 64'(pending), 0);
    tick();
    chk("sync_swap_pulse", 64'(swap), 0);

    // count on seg1, then re-request the same segment
    for (int i = 0; i < 2; i++) begin
      pulse_loop_end();
      rand_gap();
    end
    chk("seg1_rep_cnt", 64'(dbg_rep_cnt), 2);
    do_update(1, MODE_SYNC_IDX, '0);
    exp_q.push_back(1);
    pulse_loop_end();
    chk("same_seg_swap", 64'(swap), 1);
    chk("same_seg_seg", 64'(segment), 1);
    chk("same_seg_rep_cnt", 64'(dbg_rep_cnt), 0);

    // back to seg0, REP=2: STOP after the 3rd LOOP_END
    do_update(0, MODE_SYNC_IDX, '0);
    exp_q.push_back(0);
    pulse_loop_end();
    chk("to_seg0", 64'(segment), 0);
    for (int i = 1; i <= 3; i++) begin
      rand_gap();
      pulse_loop_end();
      chk("rep_stop", 64'(stop), (i == 3) ? 1 : 0);
      chk("rep_cnt", 64'(dbg_rep_cnt), (i == 3) ? 2 : i);
    end
    rand_gap();
    pulse_loop_end();
    chk("rep4_stop", 64'(stop), 1);
    chk("rep4_cnt", 64'(dbg_rep_cnt), 2);
    chk("rep4_seg", 64'(segment), 0);

    // SYNC_IDX while already stopped: swaps on the cycle after arming
    do_update(1, MODE_SYNC_IDX, '0);
    chk("stopped_pending", 64'(pending), 1);
    chk("stopped_noswap", 64'(swap), 0);
    exp_q.push_back(1);
    tick();
    chk("stopped_swap", 64'(swap), 1);
    chk("stopped_seg", 64'(segment), 1);
    chk("stopped_stop_clr", 64'(stop), 0);

    // SYS_TIME: no swap before 1000, swap once it is reached
    sys_time = 64'd980;
    do_update(2, MODE_SYS_TIME, 64'd1000);
    for (int v = 990; v < 1000; v++) begin
      sys_time = 64'(v);
      tick();
      chk("systime_early", 64'(swap), 0);
    end
    sys_time = 64'd1000;
    exp_q.push_back(2);
    tick();
    chk("systime_swap", 64'(swap), 1);
    chk("systime_seg", 64'(segment), 2);

    // seg2 is infinite: never counts, never stops
    for (int i = 0; i < 4; i++) begin
      pulse_loop_end();
      rand_gap();
    end
    chk("inf_rep_cnt", 64'(dbg_rep_cnt), 0);
    chk("inf_stop", 64'(stop), 0);

    // SYS_TIME already in the past
    sys_time = 64'd2000;
    do_update(0, MODE_SYS_TIME, 64'd500);
    exp_q.push_back(0);
    tick();
    chk("systime_past_swap", 64'(swap), 1);
    chk("systime_past_seg", 64'(segment), 0);

    // GPIO index 2: held high does not fire, other bits ignored, edge fires
    gpio_in = 4'b0100;
    tick(2);
    do_update(1, MODE_GPIO, 64'd2);
    tick(3);
    chk("gpio_held", 64'(swap), 0);
    gpio_in = 4'b0110;
    tick();
    chk("gpio_other_bit", 64'(swap), 0);
    gpio_in = 4'b0010;
    tick();
    chk("gpio_fall", 64'(swap), 0);
    gpio_in = 4'b0110;
    exp_q.push_back(1);
    tick();
    chk("gpio_rise_swap", 64'(swap), 1);
    chk("gpio_rise_seg", 64'(segment), 1);

    // rejected requests
    do_update(2'd3, MODE_SYNC_IDX, '0);
    chk("rej_seg_err", 64'(req_err), 1);
    chk("rej_seg_pending", 64'(pending), 0);
    chk("rej_seg_segment", 64'(segment), 1);
    tick();
    chk("rej_err_pulse", 64'(req_err), 0);
    do_update(1, 8'h7F, '0);
    chk("rej_mode_err", 64'(req_err), 1);
    chk("rej_mode_pending", 64'(pending), 0);
`ifndef SEGMENT_TRANSITION_EXT_EN
    do_update(0, MODE_EXT, '0);
    chk("rej_ext_err", 64'(req_err), 1);
    chk("rej_ext_pending", 64'(pending), 0);
`endif

    // rejection in WAIT keeps the armed request
    do_update(2, MODE_SYNC_IDX, '0);
    chk("arm_seg2", 64'(pending), 1);
    do_update(2'd3, MODE_SYNC_IDX, '0);
    chk("rej_wait_err", 64'(req_err), 1);
    chk("rej_wait_pending", 64'(pending), 1);

    // UPDATE coincident with trigger: no swap, new request replaces old
    req_segment     = 0;
    transition_mode = MODE_SYNC_IDX;
    update          = 1'b1;
    loop_end        = 1'b1;
    tick();
    update          = 1'b0;
    loop_end        = 1'b0;
    chk("upd_wins_swap", 64'(swap), 0);
    chk("upd_wins_pending", 64'(pending), 1);
    chk("upd_wins_seg", 64'(segment), 1);
    chk("upd_wins_counted", 64'(dbg_rep_cnt), 1);
    rand_gap();
    exp_q.push_back(0);
    pulse_loop_end();
    chk("last_write_seg", 64'(segment), 0);

`ifdef SEGMENT_TRANSITION_EXT_EN
    // EXT: swap to seg1, then auto-advance 1,1,2,0,1 with REP={0,1,0}
    begin
      logic [SEG_W-1:0] ext_seq[5];
      logic             ext_swp[5];
      ext_seq = '{2'd1, 2'd1, 2'd2, 2'd0, 2'd1};
      ext_swp = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      rep = {16'd0, 16'd1, 16'd0};
      tick();
      do_update(1, MODE_EXT, '0);
      for (int i = 0; i < 5; i++) begin
        rand_gap();
        if (ext_swp[i]) exp_q.push_back(ext_seq[i]);
        pulse_loop_end();
        chk("ext_seq", 64'(segment), 64'(ext_seq[i]));
        chk("ext_stop", 64'(stop), 0);
      end
      // a normal request ends auto-advance; seg0 then stops
      do_update(0, MODE_SYNC_IDX, '0);
      exp_q.push_back(0);
      pulse_loop_end();
      chk("ext_exit_seg", 64'(segment), 0);
      pulse_loop_end();
      chk("ext_exit_stop", 64'(stop), 1);
      chk("ext_exit_hold", 64'(segment), 0);
    end
`endif

    tick(3);
    chk("exp_q_empty", 64'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
